dmem_arbiter: RTL and testbench

- Shares the core's single data memory (9-bit word address, DATA_WIDTH data) between two requesters: the core load/store port and a debug/loader port.
- Sits between the core's memory-stage signals (read enable, write enable, address, write data, read data) and the data memory instance.
- Serialises accesses with a small FSM.
- Arbitrates round-robin and returns read data after a fixed, parameterised memory latency.

---
 rtl/dmem_arbiter_if.sv | 17 +
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one request/response port.
// The requester drives the master modport; the arbiter takes the slave modport.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core and a debug/loader
// port; one access in flight at a time, read data returned after MEM_LATENCY cycles.
module dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         core,
  dmem_arbiter_if.slave         dbg,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic       OWN_CORE = 1'b0;
  localparam logic       OWN_DBG  = 1'b1;
  localparam logic [3:0] LAT      = 4'(MEM_LATENCY);

  state_t                state_reg, state_next;
  logic                  owner_reg, owner_next;
  logic                  last_owner_reg, last_owner_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] core_rdata_reg, core_rdata_next;
  logic [DATA_WIDTH-1:0] dbg_rdata_reg, dbg_rdata_next;
  logic                  pick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_CORE;
      last_owner_reg <= OWN_DBG;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      core_rdata_reg <= '0;
      dbg_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      cnt_reg        <= cnt_next;
      core_rdata_reg <= core_rdata_next;
      dbg_rdata_reg  <= dbg_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    cnt_next        = cnt_reg;
    core_rdata_next = core_rdata_reg;
    dbg_rdata_next  = dbg_rdata_reg;
    // On a tie the port that did not own the previous access wins.
    if (core.req && dbg.req) pick = (last_owner_reg == OWN_DBG) ? OWN_CORE : OWN_DBG;
    else                     pick = core.req ? OWN_CORE : OWN_DBG;

    case (state_reg)
      IDLE: begin
        if (core.req || dbg.req) begin
          owner_next = pick;
          we_next    = (pick == OWN_DBG) ? dbg.we    : core.we;
          addr_next  = (pick == OWN_DBG) ? dbg.addr  : core.addr;
          wdata_next = (pick == OWN_DBG) ? dbg.wdata : core.wdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        last_owner_next = owner_reg;
        if (we_reg) begin
          state_next = IDLE;
        end else begin
          cnt_next   = LAT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        // Capture straight into the owner's response register so the other port's rdata holds.
        if (cnt_reg == 4'd1) begin
          if (owner_reg == OWN_DBG) dbg_rdata_next  = mem_rdata;
          else                      core_rdata_next = mem_rdata;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_we      = (state_reg == ISSUE) &&  we_reg;
  assign mem_re      = (state_reg == ISSUE) && !we_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign busy        = (state_reg != IDLE);
  assign core.gnt    = (state_reg == ISSUE) && (owner_reg == OWN_CORE);
  assign dbg.gnt     = (state_reg == ISSUE) && (owner_reg == OWN_DBG);
  assign core.rvalid = (state_reg == RESP)  && (owner_reg == OWN_CORE);
  assign dbg.rvalid  = (state_reg == RESP)  && (owner_reg == OWN_DBG);
  assign core.rdata  = core_rdata_reg;
  assign dbg.rdata   = dbg_rdata_reg;

  a_latency_range: assert property (@(posedge clk) disable iff (!rst)
    (MEM_LATENCY >= 1 && MEM_LATENCY <= 15))
    else $error("dmem_arbiter: MEM_LATENCY=%0d outside 1..15", MEM_LATENCY);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MEM_LATENCY=1, one with 4,
// each behind a small latency-accurate memory model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) c1 ();
  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) d1 ();
  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) c4 ();
  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) d4 ();

  logic        m1_re, m1_we, busy1;
  logic [8:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        m4_re, m4_we, busy4;
  logic [8:0]  m4_addr;
  logic [31:0] m4_wdata, m4_rdata;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .core(c1), .dbg(d1),
    .mem_re(m1_re), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .MEM_LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .core(c4), .dbg(d4),
    .mem_re(m4_re), .mem_we(m4_we), .mem_addr(m4_addr), .mem_wdata(m4_wdata),
    .mem_rdata(m4_rdata), .busy(busy4)
  );

  // Memory with one cycle of read latency.
  logic [31:0] mem1 [0:511];
  always @(posedge clk) begin
    if (m1_we) mem1[m1_addr] <= m1_wdata;
    if (m1_re) m1_rdata <= mem1[m1_addr];
  end

  // Memory with four cycles of read latency.
  logic [31:0] mem4 [0:511];
  logic [31:0] p4 [0:3];
  always @(posedge clk) begin
    if (m4_we) mem4[m4_addr] <= m4_wdata;
    p4[0] <= mem4[m4_addr];
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign m4_rdata = p4[3];

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({c1.gnt, d1.gnt, c1.rvalid, d1.rvalid, m1_re, m1_we, busy1} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0000000", {c1.gnt, d1.gnt, c1.rvalid, d1.rvalid, m1_re, m1_we, busy1});
    else passes++;
    checks++;
    if ({m1_addr, m1_wdata, c1.rdata, d1.rdata} !== '0)
      $display("FAIL reset_data: addr %h wdata %h crd %h drd %h expected all 0", m1_addr, m1_wdata, c1.rdata, d1.rdata);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) $display("FAIL reset_idle: busy %b expected 0", busy1); else passes++;
    $display("reset: done");
  endtask

  task automatic test_core_write();
    c1.req = 1'b1; c1.we = 1'b1; c1.addr = 9'h010; c1.wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({c1.gnt, d1.gnt, m1_we, m1_re} !== 4'b1010)
      $display("FAIL wr_strobes: gnt/dgnt/we/re %b expected 1010", {c1.gnt, d1.gnt, m1_we, m1_re});
    else passes++;
    checks++;
    if (m1_addr !== 9'h010) $display("FAIL wr_addr: got %h expected 010", m1_addr); else passes++;
    checks++;
    if (m1_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata: got %h expected deadbeef", m1_wdata); else passes++;
    c1.req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) $display("FAIL wr_busy: got %b expected 0", busy1); else passes++;
    $display("core write: addr 010 data deadbeef");
  endtask

  task automatic test_core_read();
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 9'h010;
    @(negedge clk);
    checks++;
    if ({c1.gnt, m1_re, m1_we} !== 3'b110) $display("FAIL rd_issue: gnt/re/we %b expected 110", {c1.gnt, m1_re, m1_we}); else passes++;
    c1.req = 1'b0;
    @(negedge clk);
    checks++;
    if ({c1.rvalid, busy1} !== 2'b01) $display("FAIL rd_wait: rvalid/busy %b expected 01", {c1.rvalid, busy1}); else passes++;
    @(negedge clk);
    checks++;
    if ({c1.rvalid, d1.rvalid} !== 2'b10) $display("FAIL rd_rvalid: core/dbg rvalid %b expected 10", {c1.rvalid, d1.rvalid}); else passes++;
    checks++;
    if (c1.rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", c1.rdata); else passes++;
    @(negedge clk);
    checks++;
    if ({c1.rvalid, busy1, c1.rdata} !== {2'b00, 32'hDEADBEEF})
      $display("FAIL rd_hold: rvalid %b busy %b rdata %h expected 0 0 deadbeef", c1.rvalid, busy1, c1.rdata);
    else passes++;
    $display("core read: addr 010 latency 1");
  endtask

  task automatic test_round_robin();
    logic exp_cg, exp_dg;
    int slot, turn;
    d1.req = 1'b1; d1.we = 1'b1; d1.addr = 9'h020; d1.wdata = 32'h11112222;
    @(negedge clk); d1.req = 1'b0;
    @(negedge clk);
    c1.req = 1'b1; c1.we = 1'b1; c1.addr = 9'h030; c1.wdata = 32'h33334444;
    @(negedge clk); c1.req = 1'b0;
    @(negedge clk);
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 9'h030;
    d1.req = 1'b1; d1.we = 1'b0; d1.addr = 9'h020;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      slot   = k % 4;
      turn   = (k / 4) % 2;
      exp_cg = (slot == 1) && (turn == 0);
      exp_dg = (slot == 1) && (turn == 1);
      checks++;
      if ({c1.gnt, d1.gnt} !== {exp_cg, exp_dg})
        $display("FAIL rr_gnt cycle %0d: core/dbg gnt %b expected %b", k, {c1.gnt, d1.gnt}, {exp_cg, exp_dg});
      else passes++;
      checks++;
      if (m1_re && m1_we) $display("FAIL rr_strobe cycle %0d: re and we both 1, expected at most one", k); else passes++;
      if (slot == 3) begin
        checks++;
        if (turn == 0 && !(c1.rvalid === 1'b1 && c1.rdata === 32'h33334444))
          $display("FAIL rr_core_resp cycle %0d: rvalid %b rdata %h expected 1 33334444", k, c1.rvalid, c1.rdata);
        else if (turn == 1 && !(d1.rvalid === 1'b1 && d1.rdata === 32'h11112222))
          $display("FAIL rr_dbg_resp cycle %0d: rvalid %b rdata %h expected 1 11112222", k, d1.rvalid, d1.rdata);
        else passes++;
      end
    end
    @(negedge clk);
    c1.req = 1'b0; d1.req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) $display("FAIL rr_drain: busy %b expected 0", busy1); else passes++;
    $display("round robin: 4 alternating reads");
  endtask

  task automatic test_latency4();
    d4.req = 1'b1; d4.we = 1'b1; d4.addr = 9'h1FF; d4.wdata = 32'hCAFEF00D;
    @(negedge clk); d4.req = 1'b0;
    @(negedge clk);
    d4.req = 1'b1; d4.we = 1'b0; d4.addr = 9'h1FF;
    @(negedge clk);
    checks++;
    if ({d4.gnt, m4_re, m4_addr} !== {2'b11, 9'h1FF})
      $display("FAIL l4_issue: gnt %b re %b addr %h expected 1 1 1ff", d4.gnt, m4_re, m4_addr);
    else passes++;
    d4.req = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (d4.rvalid !== 1'b0) $display("FAIL l4_early cycle %0d: rvalid %b expected 0", k, d4.rvalid); else passes++;
    end
    @(negedge clk);
    checks++;
    if ({d4.rvalid, c4.rvalid, d4.rdata} !== {2'b10, 32'hCAFEF00D})
      $display("FAIL l4_resp: dbg rvalid %b core rvalid %b rdata %h expected 1 0 cafef00d", d4.rvalid, c4.rvalid, d4.rdata);
    else passes++;
    @(negedge clk);
    $display("latency 4: dbg read 1ff");
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    c4.req = 1'b1; c4.we = 1'b0; c4.addr = 9'h1FF;
    @(negedge clk);
    c4.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) $display("FAIL rw_inflight: busy %b expected 1", busy4); else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy4, m4_re, m4_we, c4.gnt, d4.gnt} !== 5'b0)
      $display("FAIL rw_async_ctrl: busy/re/we/cg/dg %b expected 00000", {busy4, m4_re, m4_we, c4.gnt, d4.gnt});
    else passes++;
    checks++;
    if ({m4_addr, d4.rdata} !== '0) $display("FAIL rw_async_data: addr %h dbg rdata %h expected 0 0", m4_addr, d4.rdata); else passes++;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (c4.rvalid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL rw_no_rvalid: stray rvalid %b expected 0", seen); else passes++;
    c4.req = 1'b1; c4.we = 1'b1; c4.addr = 9'h005; c4.wdata = 32'h1;
    d4.req = 1'b1; d4.we = 1'b1; d4.addr = 9'h006; d4.wdata = 32'h2;
    @(negedge clk);
    checks++;
    if ({c4.gnt, d4.gnt} !== 2'b10) $display("FAIL rw_tie: core/dbg gnt %b expected 10", {c4.gnt, d4.gnt}); else passes++;
    c4.req = 1'b0; d4.req = 1'b0;
    @(negedge clk);
    $display("reset in wait: abandoned read, tie to core");
  endtask

  task automatic test_dbg_pulse();
    logic seen;
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 9'h010;
    @(negedge clk);
    c1.req = 1'b0;
    seen = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) begin d1.req = 1'b1; d1.we = 1'b0; d1.addr = 9'h020; end
      if (k == 3) d1.req = 1'b0;
      if (d1.gnt !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL pulse_ignored: dbg gnt seen %b expected 0", seen); else passes++;
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 9'h010;
    @(negedge clk);
    c1.req = 1'b0;
    @(negedge clk);
    d1.req = 1'b1; d1.we = 1'b1; d1.addr = 9'h040; d1.wdata = 32'h55;
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (d1.gnt !== 1'b0) $display("FAIL held_early cycle %0d: dbg gnt %b expected 0", k, d1.gnt); else passes++;
    end
    @(negedge clk);
    checks++;
    if ({d1.gnt, m1_we, m1_addr} !== {2'b11, 9'h040})
      $display("FAIL held_gnt: gnt %b we %b addr %h expected 1 1 040", d1.gnt, m1_we, m1_addr);
    else passes++;
    d1.req = 1'b0;
    @(negedge clk);
    $display("dbg pulse ignored, held dbg granted at cycle 5");
  endtask

  initial begin
    c1.req = 1'b0; c1.we = 1'b0; c1.addr = '0; c1.wdata = '0;
    d1.req = 1'b0; d1.we = 1'b0; d1.addr = '0; d1.wdata = '0;
    c4.req = 1'b0; c4.we = 1'b0; c4.addr = '0; c4.wdata = '0;
    d4.req = 1'b0; d4.we = 1'b0; d4.addr = '0; d4.wdata = '0;
    test_reset();
    test_core_write();
    test_core_read();
    test_round_robin();
    test_latency4();
    test_reset_in_wait();
    test_dbg_pulse();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
